// File: rtl/if_fetch_stage_if.sv
// Instruction-memory fetch bus: a req/ack handshake with a word address and returned data.
// The fetch stage is the master and the memory is the slave.
interface if_fetch_stage_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, addr, input  ack, rdata);
  modport slave  (input  req, addr, output ack, rdata);
endinterface

// File: rtl/if_fetch_stage.sv
// Fetch stage: owns the PC, runs the imem handshake and fills the IF/ID register.
// A one-entry skid buffer absorbs a decode stall, and DRAIN discards the response that is
// still in flight when EX redirects.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  if_fetch_stage_if.master         imem,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  input  logic                     id_stall,
  output logic                     if_id_valid,
  output logic [31:0]              if_id_instr,
  output logic [31:0]              if_id_pc,
  output logic [31:0]              if_id_pc4
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_word_t;

  state_t      state, state_nx;
  logic [31:0] pc, target;
  fetch_word_t skid;
  logic [31:0] redir_pc;

  assign redir_pc = {redirect_pc[31:2], 2'b00};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  state_nx = FETCH;
      FETCH: begin
        if (redirect_valid)                          state_nx = imem.ack ? FETCH : DRAIN;
        else if (imem.ack && id_stall && if_id_valid) state_nx = HOLD;
      end
      HOLD:  if (redirect_valid || !id_stall) state_nx = FETCH;
      // A redirect that lands together with the ack goes straight to its own target.
      DRAIN: if (imem.ack) state_nx = FETCH;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    imem.req  = (state == FETCH) || (state == DRAIN);
    imem.addr = pc;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc          <= RESET_PC;
      target      <= RESET_PC;
      skid        <= '0;
      if_id_valid <= 1'b0;
      if_id_instr <= NOP_INSTR;
      if_id_pc    <= 32'h0;
      if_id_pc4   <= 32'h0;
    end else begin
      case (state)
        FETCH: begin
          if (redirect_valid) begin
            if_id_valid <= 1'b0;
            if_id_instr <= NOP_INSTR;
            if (imem.ack) pc     <= redir_pc;
            else          target <= redir_pc;
          end else if (imem.ack) begin
            pc <= pc + 32'd4;
            if (!id_stall || !if_id_valid) begin
              if_id_valid <= 1'b1;
              if_id_instr <= imem.rdata;
              if_id_pc    <= pc;
              if_id_pc4   <= pc + 32'd4;
            end else begin
              skid <= '{instr: imem.rdata, pc: pc};
            end
          end else if (!id_stall) begin
            if_id_valid <= 1'b0;
            if_id_instr <= NOP_INSTR;
          end
        end
        HOLD: begin
          if (redirect_valid) begin
            if_id_valid <= 1'b0;
            if_id_instr <= NOP_INSTR;
            pc          <= redir_pc;
          end else if (!id_stall) begin
            if_id_valid <= 1'b1;
            if_id_instr <= skid.instr;
            if_id_pc    <= skid.pc;
            if_id_pc4   <= skid.pc + 32'd4;
          end
        end
        DRAIN: begin
          if (imem.ack)           pc     <= redirect_valid ? redir_pc : target;
          else if (redirect_valid) target <= redir_pc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage. The memory model returns ~addr after a programmable wait.
// A second instance, with RESET_PC at the top of memory, checks PC wrap-around.
module tb_if_fetch_stage;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        id_stall = 1'b0;
  logic        v1, v2;
  logic [31:0] i1, p1, q1, i2, p2, q2;
  int          lat = 0;
  int          wcnt;
  int          n_cmp = 0;
  int          n_bad = 0;

  if_fetch_stage_if m1 ();
  if_fetch_stage_if m2 ();

  // Memory model: ack arrives once req has been waiting lat cycles.
  assign m1.ack   = m1.req && (wcnt >= lat);
  assign m1.rdata = ~m1.addr;
  always @(posedge clk or negedge rst)
    if (!rst)                  wcnt <= 0;
    else if (!m1.req || m1.ack) wcnt <= 0;
    else                       wcnt <= wcnt + 1;

  assign m2.ack   = m2.req;
  assign m2.rdata = ~m2.addr;

  if_fetch_stage dut (
    .clk(clk), .rst(rst), .imem(m1),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .id_stall(id_stall),
    .if_id_valid(v1), .if_id_instr(i1), .if_id_pc(p1), .if_id_pc4(q1));

  if_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst), .imem(m2),
    .redirect_valid(1'b0), .redirect_pc(32'h0), .id_stall(1'b0),
    .if_id_valid(v2), .if_id_instr(i2), .if_id_pc(p2), .if_id_pc4(q2));

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int l);
    rst = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; id_stall = 1'b0; lat = l;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    step();
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (m1.req !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %0b want 0", m1.req); end
    n_cmp++; if (v1 !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %0b want 0", v1); end
    n_cmp++; if (i1 !== 32'h0) begin n_bad++; $display("FAIL reset_instr: got %h want 0", i1); end
    n_cmp++; if (p1 !== 32'h0 || q1 !== 32'h0) begin n_bad++; $display("FAIL reset_pc: got %h/%h want 0/0", p1, q1); end
    rst = 1'b1;
    #2;
    n_cmp++; if (m1.req !== 1'b0) begin n_bad++; $display("FAIL idle_req: got %0b want 0", m1.req); end
    step();
    n_cmp++; if (m1.req !== 1'b1 || m1.addr !== 32'h0) begin n_bad++; $display("FAIL first_fetch: got req %0b addr %h want 1/0", m1.req, m1.addr); end
  endtask

  task automatic test_stream;
    logic [31:0] e;
    do_reset(0);
    for (int k = 0; k < 4; k++) begin
      step();
      e = 32'(4 * k);
      n_cmp++;
      if (v1 !== 1'b1 || p1 !== e || i1 !== ~e || q1 !== e + 32'd4) begin
        n_bad++; $display("FAIL stream[%0d]: got v%0b pc %h instr %h pc4 %h want v1 pc %h", k, v1, p1, i1, q1, e);
      end
    end
  endtask

  task automatic test_latency;
    int ev[7];
    int ea[7];
    ev = '{0, 0, 0, 1, 0, 0, 1};
    ea = '{0, 0, 0, 4, 4, 4, 8};
    do_reset(2);
    for (int s = 0; s < 7; s++) begin
      n_cmp++;
      if (m1.req !== 1'b1 || m1.addr !== 32'(ea[s])) begin
        n_bad++; $display("FAIL lat_addr[%0d]: got req %0b addr %h want 1/%h", s, m1.req, m1.addr, ea[s]);
      end
      n_cmp++;
      if (v1 !== ev[s][0] || (ev[s] == 0 && i1 !== 32'h0)) begin
        n_bad++; $display("FAIL lat_valid[%0d]: got v%0b instr %h want v%0d", s, v1, i1, ev[s]);
      end
      if (s < 6) step();
    end
    n_cmp++; if (p1 !== 32'h4 || i1 !== ~32'h4) begin n_bad++; $display("FAIL lat_word: got pc %h instr %h want 4", p1, i1); end
  endtask

  task automatic test_stall;
    do_reset(0);
    id_stall = 1'b1;
    step();
    n_cmp++; if (v1 !== 1'b1 || p1 !== 32'h0 || m1.addr !== 32'h4) begin n_bad++; $display("FAIL stall_first: got v%0b pc %h addr %h want v1 0 4", v1, p1, m1.addr); end
    step();
    for (int s = 0; s < 4; s++) begin
      n_cmp++;
      if (m1.req !== 1'b0 || v1 !== 1'b1 || p1 !== 32'h0 || i1 !== ~32'h0) begin
        n_bad++; $display("FAIL stall_hold[%0d]: got req %0b v%0b pc %h want req 0 v1 pc 0", s, m1.req, v1, p1);
      end
      if (s == 3) id_stall = 1'b0;
      step();
    end
    n_cmp++; if (v1 !== 1'b1 || p1 !== 32'h4 || i1 !== ~32'h4 || q1 !== 32'h8) begin n_bad++; $display("FAIL skid_out: got v%0b pc %h instr %h want v1 pc 4", v1, p1, i1); end
    n_cmp++; if (m1.req !== 1'b1 || m1.addr !== 32'h8) begin n_bad++; $display("FAIL skid_resume: got req %0b addr %h want 1/8", m1.req, m1.addr); end
    step();
    n_cmp++; if (v1 !== 1'b1 || p1 !== 32'h8) begin n_bad++; $display("FAIL skid_next: got v%0b pc %h want v1 pc 8", v1, p1); end
  endtask

  task automatic test_redirect_drain;
    do_reset(2);
    redirect_valid = 1'b1; redirect_pc = 32'h43;
    step();
    redirect_valid = 1'b0;
    n_cmp++; if (m1.req !== 1'b1 || m1.addr !== 32'h0 || v1 !== 1'b0) begin n_bad++; $display("FAIL drain_hold: got req %0b addr %h v%0b want 1/0/0", m1.req, m1.addr, v1); end
    step();
    n_cmp++; if (m1.addr !== 32'h0 || v1 !== 1'b0) begin n_bad++; $display("FAIL drain_ack: got addr %h v%0b want 0/0", m1.addr, v1); end
    step();
    n_cmp++; if (m1.req !== 1'b1 || m1.addr !== 32'h40) begin n_bad++; $display("FAIL drain_target: got req %0b addr %h want 1/40", m1.req, m1.addr); end
    for (int s = 0; s < 3; s++) begin
      n_cmp++; if (v1 !== 1'b0) begin n_bad++; $display("FAIL drain_bubble[%0d]: got v%0b want 0", s, v1); end
      step();
    end
    n_cmp++; if (v1 !== 1'b1 || p1 !== 32'h40 || i1 !== ~32'h40 || q1 !== 32'h44) begin n_bad++; $display("FAIL drain_word: got v%0b pc %h instr %h want v1 pc 40", v1, p1, i1); end
  endtask

  task automatic test_redirect_ack_stall;
    do_reset(0);
    step();
    id_stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h80;
    step();
    redirect_valid = 1'b0;
    n_cmp++; if (v1 !== 1'b0 || i1 !== 32'h0) begin n_bad++; $display("FAIL flush: got v%0b instr %h want 0/0", v1, i1); end
    n_cmp++; if (m1.req !== 1'b1 || m1.addr !== 32'h80) begin n_bad++; $display("FAIL flush_addr: got req %0b addr %h want 1/80", m1.req, m1.addr); end
    step();
    n_cmp++; if (v1 !== 1'b1 || p1 !== 32'h80 || i1 !== ~32'h80) begin n_bad++; $display("FAIL flush_next: got v%0b pc %h want v1 pc 80", v1, p1); end
    id_stall = 1'b0;
  endtask

  task automatic test_wrap;
    do_reset(0);
    n_cmp++; if (m2.addr !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_first: got %h want fffffffc", m2.addr); end
    step();
    n_cmp++; if (m2.addr !== 32'h0) begin n_bad++; $display("FAIL wrap_addr: got %h want 0", m2.addr); end
    n_cmp++; if (v2 !== 1'b1 || p2 !== 32'hFFFF_FFFC || q2 !== 32'h0) begin n_bad++; $display("FAIL wrap_pc4: got v%0b pc %h pc4 %h want v1 fffffffc 0", v2, p2, q2); end
    step();
    n_cmp++; if (p2 !== 32'h0 || q2 !== 32'h4 || i2 !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL wrap_next: got pc %h pc4 %h instr %h want 0/4/ffffffff", p2, q2, i2); end
  endtask

  task automatic test_reset_mid_drain;
    do_reset(0);
    repeat (3) step();
    lat = 5; redirect_valid = 1'b1; redirect_pc = 32'h100;
    step();
    redirect_valid = 1'b0;
    n_cmp++; if (m1.req !== 1'b1 || m1.addr !== 32'hC || p1 !== 32'h8 || q1 !== 32'hC) begin n_bad++; $display("FAIL pre_reset: got req %0b addr %h pc %h want 1/c/8", m1.req, m1.addr, p1); end
    rst = 1'b0;
    #1;
    n_cmp++; if (m1.req !== 1'b0) begin n_bad++; $display("FAIL async_req: got %0b want 0", m1.req); end
    n_cmp++; if (v1 !== 1'b0 || i1 !== 32'h0 || p1 !== 32'h0 || q1 !== 32'h0) begin n_bad++; $display("FAIL async_ifid: got v%0b %h %h %h want 0", v1, i1, p1, q1); end
    n_cmp++; if (m1.addr !== 32'h0) begin n_bad++; $display("FAIL async_pc: got %h want 0", m1.addr); end
    #3 rst = 1'b1; lat = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_stream();
    test_latency();
    test_stall();
    test_redirect_drain();
    test_redirect_ack_stall();
    test_wrap();
    test_reset_mid_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
